// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG marker sequencer: marker codes, FSM states,
// error codes, target-select bit positions and the code-class record.
package jpeg_pkg;

  localparam logic [7:0] M_SOI  = 8'hD8;
  localparam logic [7:0] M_EOI  = 8'hD9;
  localparam logic [7:0] M_SOS  = 8'hDA;
  localparam logic [7:0] M_DQT  = 8'hDB;
  localparam logic [7:0] M_DHT  = 8'hC4;
  localparam logic [7:0] M_SOF0 = 8'hC0;
  localparam logic [7:0] M_RST0 = 8'hD0;
  localparam logic [7:0] M_RST7 = 8'hD7;
  localparam logic [7:0] M_FILL = 8'hFF;

  localparam int SEL_DQT  = 0;
  localparam int SEL_DHT  = 1;
  localparam int SEL_SOF0 = 2;
  localparam int SEL_SOS  = 3;
  localparam logic [3:0] SEL_SOS_M = 4'b1000;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_NO_SOI    = 3'd1;
  localparam logic [2:0] ERR_NO_FF     = 3'd2;
  localparam logic [2:0] ERR_BAD_LEN   = 3'd3;
  localparam logic [2:0] ERR_UNSUP     = 3'd4;
  localparam logic [2:0] ERR_EOI_EARLY = 3'd5;
  localparam logic [2:0] ERR_ECS       = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SOI_FF, ST_SOI_D8, ST_MRK_FF, ST_MRK_CODE,
    ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD, ST_SKIP, ST_ECS, ST_ECS_FF
  } state_t;

  // Classification of a marker code byte; at most one field is set.
  typedef struct packed {
    logic [3:0] target;
    logic       skip;
    logic       unsup;
    logic       eoi;
    logic       rst;
  } mrk_class_t;

endpackage

// File: rtl/jpeg_marker_ctrl_if.sv
// Byte-source / segment-parser bus of the marker sequencer.
interface jpeg_marker_ctrl_if;
  logic       i_start;
  logic       i_abort;
  logic       i_byte_en;
  logic [7:0] i_byte;
  logic       o_ready;
  logic [3:0] o_sel;
  logic       o_seg_byte_en;
  logic [7:0] o_seg_byte;
  logic [3:0] i_seg_ready;
  logic       o_seg_first;
  logic       o_seg_last;
  logic       o_ecs_en;
  logic       o_rst_mrk;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [2:0] o_err_code;

  modport slave (
    input  i_start, i_abort, i_byte_en, i_byte, i_seg_ready,
    output o_ready, o_sel, o_seg_byte_en, o_seg_byte, o_seg_first, o_seg_last,
           o_ecs_en, o_rst_mrk, o_busy, o_done, o_err, o_err_code
  );

  modport master (
    output i_start, i_abort, i_byte_en, i_byte, i_seg_ready,
    input  o_ready, o_sel, o_seg_byte_en, o_seg_byte, o_seg_first, o_seg_last,
           o_ecs_en, o_rst_mrk, o_busy, o_done, o_err, o_err_code
  );
endinterface

// File: rtl/jpeg_marker_decode.sv
// Combinational marker-code classifier shared by header and ECS parsing.
// FF (fill) produces an all-zero class; callers test for it themselves.
module jpeg_marker_decode
  import jpeg_pkg::*;
(
  input  logic [7:0] code,
  output mrk_class_t cls
);

  // Priority chain: routed targets, EOI, RSTn, unsupported SOFn/SOI, else skip.
  always_comb begin
    cls = '0;
    if (code == M_DQT)                           cls.target[SEL_DQT]  = 1'b1;
    else if (code == M_DHT)                      cls.target[SEL_DHT]  = 1'b1;
    else if (code == M_SOF0)                     cls.target[SEL_SOF0] = 1'b1;
    else if (code == M_SOS)                      cls.target[SEL_SOS]  = 1'b1;
    else if (code == M_EOI)                      cls.eoi   = 1'b1;
    else if (code >= M_RST0 && code <= M_RST7)   cls.rst   = 1'b1;
    else if (code == M_SOI ||
             (code[7:4] == 4'hC && code != 8'hC8 && code != 8'hCC))
                                                 cls.unsup = 1'b1;
    else if (code != M_FILL)                     cls.skip  = 1'b1;
  end

endmodule

// File: rtl/jpeg_marker_ctrl.sv
// JPEG marker sequencer: checks SOI, walks marker segments, routes payload
// bytes to the selected parser, skips unused segments and de-stuffs the ECS.
module jpeg_marker_ctrl
  import jpeg_pkg::*;
(
  input logic              i_sysclk,
  input logic              i_arst,
  jpeg_marker_ctrl_if.slave bus
);

  state_t      state, state_nxt;
  mrk_class_t  cls;
  logic [3:0]  sel;
  logic        seg_sos, seg_skip, seg_first;
  logic [7:0]  len_hi;
  logic [15:0] cnt, len;
  logic [2:0]  err_code, err_code_nxt;
  logic        done_q, err_q, rst_q;
  logic        err_now, done_now, rst_now;
  logic        fwd, ready, accept;

  jpeg_marker_decode u_dec (.code(bus.i_byte), .cls(cls));

  assign len    = {len_hi, bus.i_byte};
  assign accept = |(sel & bus.i_seg_ready);

  // State register.
  always_ff @(posedge i_sysclk) begin
    if (i_arst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: abort first, then start in IDLE, then per consumed byte.
  always_comb begin
    state_nxt    = state;
    err_now      = 1'b0;
    err_code_nxt = ERR_NONE;
    done_now     = 1'b0;
    rst_now      = 1'b0;
    if (bus.i_abort) begin
      state_nxt = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (bus.i_start) state_nxt = ST_SOI_FF;
    end else if (ready) begin
      case (state)
        ST_SOI_FF: if (bus.i_byte == M_FILL) state_nxt = ST_SOI_D8;
                   else begin err_now = 1'b1; err_code_nxt = ERR_NO_SOI; end
        ST_SOI_D8: if (bus.i_byte == M_SOI) state_nxt = ST_MRK_FF;
                   else begin err_now = 1'b1; err_code_nxt = ERR_NO_SOI; end
        ST_MRK_FF: if (bus.i_byte == M_FILL) state_nxt = ST_MRK_CODE;
                   else begin err_now = 1'b1; err_code_nxt = ERR_NO_FF; end
        ST_MRK_CODE: begin
          if (bus.i_byte == M_FILL)          state_nxt = ST_MRK_CODE;
          else if (|cls.target || cls.skip)  state_nxt = ST_LEN_HI;
          else if (cls.eoi) begin err_now = 1'b1; err_code_nxt = ERR_EOI_EARLY; end
          else begin err_now = 1'b1; err_code_nxt = ERR_UNSUP; end
        end
        ST_LEN_HI: state_nxt = ST_LEN_LO;
        ST_LEN_LO: begin
          if (len < 16'd2) begin err_now = 1'b1; err_code_nxt = ERR_BAD_LEN; end
          else if (len == 16'd2) state_nxt = seg_sos ? ST_ECS : ST_MRK_FF;
          else state_nxt = seg_skip ? ST_SKIP : ST_PAYLOAD;
        end
        ST_PAYLOAD, ST_SKIP:
          if (cnt == 16'd1) state_nxt = seg_sos ? ST_ECS : ST_MRK_FF;
        ST_ECS: if (bus.i_byte == M_FILL) state_nxt = ST_ECS_FF;
        ST_ECS_FF: begin
          if (bus.i_byte == 8'h00)        state_nxt = ST_ECS;
          else if (bus.i_byte == M_FILL)  state_nxt = ST_ECS_FF;
          else if (cls.rst) begin rst_now = 1'b1; state_nxt = ST_ECS; end
          else if (cls.eoi) begin done_now = 1'b1; state_nxt = ST_IDLE; end
          else begin err_now = 1'b1; err_code_nxt = ERR_ECS; end
        end
        default: state_nxt = state;
      endcase
      if (err_now) state_nxt = ST_IDLE;
    end
  end

  // Outputs: forward qualification and zero-latency ready.
  always_comb begin
    fwd   = 1'b0;
    ready = 1'b0;
    case (state)
      ST_PAYLOAD: fwd = bus.i_byte_en;
      ST_ECS:     fwd = bus.i_byte_en && (bus.i_byte != M_FILL);
      ST_ECS_FF:  fwd = bus.i_byte_en && (bus.i_byte == 8'h00);
      default:    fwd = 1'b0;
    endcase
    if (bus.i_abort) fwd = 1'b0;
    if (bus.i_abort || state == ST_IDLE) ready = 1'b0;
    else if (fwd)                        ready = accept;
    else                                 ready = bus.i_byte_en;
  end

  // Segment context, length counter, sticky error code and event pulses.
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      sel <= '0; seg_sos <= 1'b0; seg_skip <= 1'b0; seg_first <= 1'b0;
      len_hi <= '0; cnt <= '0; err_code <= ERR_NONE;
      done_q <= 1'b0; err_q <= 1'b0; rst_q <= 1'b0;
    end else begin
      done_q <= done_now;
      err_q  <= err_now;
      rst_q  <= rst_now;
      if (err_now) err_code <= err_code_nxt;
      if (bus.i_abort) begin
        sel <= '0; cnt <= '0; seg_sos <= 1'b0; seg_skip <= 1'b0; seg_first <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (bus.i_start) begin
          err_code <= ERR_NONE; sel <= '0; cnt <= '0;
          seg_sos <= 1'b0; seg_skip <= 1'b0;
        end
      end else if (ready) begin
        case (state)
          ST_MRK_CODE:
            if (|cls.target) begin
              sel <= cls.target; seg_sos <= cls.target[SEL_SOS]; seg_skip <= 1'b0;
            end else if (cls.skip) begin
              sel <= '0; seg_sos <= 1'b0; seg_skip <= 1'b1;
            end
          ST_LEN_HI: len_hi <= bus.i_byte;
          ST_LEN_LO: begin cnt <= len - 16'd2; seg_first <= 1'b1; end
          ST_PAYLOAD, ST_SKIP: begin cnt <= cnt - 16'd1; seg_first <= 1'b0; end
          default: ;
        endcase
        if (state_nxt == ST_ECS) sel <= SEL_SOS_M;
        if (state_nxt == ST_IDLE) begin sel <= '0; cnt <= '0; end
      end
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_sel         = sel;
  assign bus.o_seg_byte_en = fwd;
  assign bus.o_seg_byte    = !fwd ? 8'h00 : (state == ST_ECS_FF) ? M_FILL : bus.i_byte;
  assign bus.o_seg_first   = ready && (state == ST_PAYLOAD) && seg_first;
  assign bus.o_seg_last    = ready && (state == ST_PAYLOAD) && (cnt == 16'd1);
  assign bus.o_ecs_en      = (state == ST_ECS) || (state == ST_ECS_FF);
  assign bus.o_rst_mrk     = rst_q;
  assign bus.o_busy        = (state != ST_IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_err_code    = err_code;

endmodule
